// File: rtl/sram_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM data-memory controller.
// The helper builds the SRAM half-word address from a word index.
package sram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } sram_state_t;

   localparam int SRAM_ADDR_W           = 18;
   localparam int SRAM_DATA_W           = 16;
   localparam int DATA_MEM_BASE_DEFAULT = 1024;

   // Word index occupies the upper bits, the half-word select is the LSB.
   function automatic logic [SRAM_ADDR_W-1:0] half_addr(
      input logic [SRAM_ADDR_W-2:0] word_idx,
      input logic                   upper
   );
      return {word_idx, upper};
   endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Splits each 32-bit MEM-stage access into two 16-bit SRAM phases with programmable wait
// cycles; ready stays low for the whole access so the pipeline freezes until it completes.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int          WAIT_CYCLES   = 1,
   parameter logic [31:0] DATA_MEM_BASE = 32'(DATA_MEM_BASE_DEFAULT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   inout  wire  [SRAM_DATA_W-1:0] sram_dq,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic                   sram_we_n,
   output logic                   sram_ub_n,
   output logic                   sram_lb_n,
   output logic                   sram_ce_n,
   output logic                   sram_oe_n
);

   localparam int               CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
   localparam int               WORD_W   = SRAM_ADDR_W - 1;

   sram_state_t                state_r;
   sram_state_t                state_s;
   logic [CNT_W-1:0]           cnt_r;
   logic [CNT_W-1:0]           cnt_s;
   logic                       op_wr_r;
   logic [WORD_W-1:0]          word_r;
   logic [31:0]                wdata_r;
   logic                       dq_oe_r;
   logic [SRAM_DATA_W-1:0]     dq_out_r;

   logic                       req_s;
   logic                       start_s;
   logic                       phase_last_s;
   logic [31:0]                off_s;
   logic [WORD_W-1:0]          word_s;
   logic                       unused_off_bits_s;

   logic                       src_wr_s;
   logic [WORD_W-1:0]          src_word_s;
   logic [31:0]                src_wdata_s;
   logic [SRAM_ADDR_W-1:0]     addr_nxt_s;
   logic                       we_n_nxt_s;
   logic                       dq_oe_nxt_s;
   logic [SRAM_DATA_W-1:0]     dq_out_nxt_s;
   logic                       cap_lo_s;
   logic                       cap_hi_s;

   // Offset wraps modulo 2^32; only bits [18:2] select the SRAM word.
   assign off_s             = address - DATA_MEM_BASE;
   assign word_s            = off_s[SRAM_ADDR_W:2];
   assign unused_off_bits_s = ^{off_s[31:SRAM_ADDR_W+1], off_s[1:0]};

   assign req_s        = wr_en | rd_en;
   assign start_s      = (state_r == IDLE) && req_s;
   assign phase_last_s = (cnt_r == CNT_LAST);

   assign ready = ((state_r == IDLE) && !req_s) || (state_r == DONE);

   assign sram_dq   = dq_oe_r ? dq_out_r : {SRAM_DATA_W{1'bz}};
   assign sram_ub_n = 1'b0;
   assign sram_lb_n = 1'b0;
   assign sram_ce_n = 1'b0;
   assign sram_oe_n = 1'b0;

   // Next-state and wait-counter sequencing.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               state_s = LO;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = IDLE;
            end
         end
         LO: begin
            if (phase_last_s) begin
               state_s = HI;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         HI: begin
            if (phase_last_s) begin
               state_s = DONE;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Pad values for the coming cycle; on the starting edge take the live request fields.
   always_comb begin
      if (start_s) begin
         src_wr_s    = wr_en;
         src_word_s  = word_s;
         src_wdata_s = write_data;
      end else begin
         src_wr_s    = op_wr_r;
         src_word_s  = word_r;
         src_wdata_s = wdata_r;
      end
      addr_nxt_s   = sram_addr;
      we_n_nxt_s   = 1'b1;
      dq_oe_nxt_s  = 1'b0;
      dq_out_nxt_s = dq_out_r;
      case (state_s)
         LO: begin
            addr_nxt_s   = half_addr(src_word_s, 1'b0);
            we_n_nxt_s   = !src_wr_s;
            dq_oe_nxt_s  = src_wr_s;
            dq_out_nxt_s = src_wdata_s[15:0];
         end
         HI: begin
            addr_nxt_s   = half_addr(src_word_s, 1'b1);
            we_n_nxt_s   = !src_wr_s;
            dq_oe_nxt_s  = src_wr_s;
            dq_out_nxt_s = src_wdata_s[31:16];
         end
         default: begin
            addr_nxt_s  = sram_addr;
            we_n_nxt_s  = 1'b1;
            dq_oe_nxt_s = 1'b0;
         end
      endcase
   end

   // Read data is sampled on the final wait cycle of each phase.
   always_comb begin
      if (!op_wr_r && phase_last_s) begin
         cap_lo_s = (state_r == LO);
         cap_hi_s = (state_r == HI);
      end else begin
         cap_lo_s = 1'b0;
         cap_hi_s = 1'b0;
      end
   end

   // Controller state, latched request and registered SRAM pads.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         op_wr_r   <= 1'b0;
         word_r    <= {WORD_W{1'b0}};
         wdata_r   <= 32'h0000_0000;
         sram_addr <= {SRAM_ADDR_W{1'b0}};
         sram_we_n <= 1'b1;
         dq_oe_r   <= 1'b0;
         dq_out_r  <= {SRAM_DATA_W{1'b0}};
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         sram_addr <= addr_nxt_s;
         sram_we_n <= we_n_nxt_s;
         dq_oe_r   <= dq_oe_nxt_s;
         dq_out_r  <= dq_out_nxt_s;
         if (start_s) begin
            op_wr_r <= wr_en;
            word_r  <= word_s;
            wdata_r <= write_data;
         end
      end
   end

   // Load result register; writes leave it untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         read_data <= 32'h0000_0000;
      end else begin
         if (cap_lo_s) begin
            read_data[15:0] <= sram_dq;
         end
         if (cap_hi_s) begin
            read_data[31:16] <= sram_dq;
         end
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (W=1, W=0), each with a behavioural async SRAM,
// a vector table, hand-written corner sequences and a randomized run against a word-level model.
module tb_sram_ctrl;
   import sram_pkg::*;

   localparam int W1 = 1;
   localparam int W0 = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic mem_clr;

   logic        wr1, rd1, wr0, rd0;
   logic [31:0] addr1, wd1, addr0, wd0;
   wire  [31:0] rdata1, rdata0;
   wire         ready1, ready0;
   wire  [15:0] dq1, dq0;
   wire  [17:0] sa1, sa0;
   wire         we1, ub1, lb1, ce1, oe1;
   wire         we0, ub0, lb0, ce0, oe0;

   sram_ctrl #(.WAIT_CYCLES(W1), .DATA_MEM_BASE(32'd1024)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(addr1),
      .write_data(wd1), .read_data(rdata1), .ready(ready1), .sram_dq(dq1),
      .sram_addr(sa1), .sram_we_n(we1), .sram_ub_n(ub1), .sram_lb_n(lb1),
      .sram_ce_n(ce1), .sram_oe_n(oe1)
   );

   sram_ctrl #(.WAIT_CYCLES(W0), .DATA_MEM_BASE(32'd1024)) dut0 (
      .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .address(addr0),
      .write_data(wd0), .read_data(rdata0), .ready(ready0), .sram_dq(dq0),
      .sram_addr(sa0), .sram_we_n(we0), .sram_ub_n(ub0), .sram_lb_n(lb0),
      .sram_ce_n(ce0), .sram_oe_n(oe0)
   );

   // Behavioural async SRAMs: output enabled whenever not writing.
   logic [15:0] mem1 [0:262143];
   logic [15:0] mem0 [0:262143];
   assign dq1 = we1 ? mem1[sa1] : 16'hzzzz;
   assign dq0 = we0 ? mem0[sa0] : 16'hzzzz;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 262144; i++) begin
            mem1[i] <= 16'h0000;
            mem0[i] <= 16'h0000;
         end
      end else begin
         if (!we1) mem1[sa1] <= dq1;
         if (!we0) mem0[sa0] <= dq0;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] refm [int];
   logic [31:0] cur_rd [2];

   typedef struct {
      logic        w;
      logic        r;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      logic [17:0] exp_lo;
   } vec_t;
   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic f_ready(input int s);
      return (s == 1) ? ready1 : ready0;
   endfunction
   function automatic logic f_we(input int s);
      return (s == 1) ? we1 : we0;
   endfunction
   function automatic logic [31:0] f_rdata(input int s);
      return (s == 1) ? rdata1 : rdata0;
   endfunction
   function automatic logic [17:0] f_addr(input int s);
      return (s == 1) ? sa1 : sa0;
   endfunction
   function automatic logic [15:0] f_dq(input int s);
      return (s == 1) ? dq1 : dq0;
   endfunction
   function automatic logic [15:0] f_mem(input int s, input logic [17:0] i);
      return (s == 1) ? mem1[i] : mem0[i];
   endfunction

   task automatic drive(input int s, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d);
      if (s == 1) begin
         wr1 = w; rd1 = r; addr1 = a; wd1 = d;
      end else begin
         wr0 = w; rd0 = r; addr0 = a; wd0 = d;
      end
   endtask

   task automatic idle(input int s);
      @(negedge clk);
      drive(s, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // One access: request shown in an IDLE cycle (cycle 0), checked every cycle until DONE.
   task automatic do_access(input int s, input logic w, input logic r,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_rd, input logic [17:0] exp_lo);
      int  wc;
      int  c;
      bit  done;
      wc = (s == 1) ? W1 : W0;
      @(negedge clk);
      drive(s, w, r, a, d);
      #1;
      chk("ready_cycle0", {31'b0, f_ready(s)}, 32'd0);
      done = 1'b0;
      c    = 0;
      while (!done && c < 40) begin
         @(negedge clk);
         #1;
         c++;
         if (f_ready(s)) begin
            done = 1'b1;
            chk("frozen_cycles", 32'(c), 32'(2 * wc + 3));
            chk("done_read_data", f_rdata(s), exp_rd);
         end else if (c <= 2 * wc + 2) begin
            chk("sram_addr", {14'b0, f_addr(s)},
                {14'b0, (c <= wc + 1) ? exp_lo : (exp_lo + 18'd1)});
            chk("sram_we_n", {31'b0, f_we(s)}, w ? 32'd0 : 32'd1);
            if (w) begin
               chk("sram_dq_drive", {16'b0, f_dq(s)},
                   {16'b0, (c <= wc + 1) ? d[15:0] : d[31:16]});
            end
         end
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout: ready never returned, got 0 expected 1");
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return ((a - 32'd1024) / 32'd4) % 32'd131072;
   endfunction

   task automatic check_write_mem(input int s, input logic [17:0] lo, input logic [31:0] d);
      chk("mem_lower_half", {16'b0, f_mem(s, lo)}, {16'b0, d[15:0]});
      chk("mem_upper_half", {16'b0, f_mem(s, lo + 18'd1)}, {16'b0, d[31:16]});
   endtask

   initial begin
      rst = 1'b1;
      mem_clr = 1'b1;
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      mem_clr = 1'b0;
      cur_rd[0] = 32'h0;
      cur_rd[1] = 32'h0;

      // Reset state with no requests.
      chk("tieoffs", {28'b0, ub1, lb1, ce1, oe1}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         chk("rst_ready", {31'b0, ready1}, 32'd1);
         chk("rst_we_n", {31'b0, we1}, 32'd1);
         chk("rst_read_data", rdata1, 32'h0);
         chk("rst_sram_addr", {14'b0, sa1}, 32'h0);
         chk("rst_bus_released", {16'b0, dq1}, 32'h0);
         chk("rst_ready_w0", {31'b0, ready0}, 32'd1);
      end

      // Vector table on the W=1 instance.
      tbl[0] = '{w: 1'b1, r: 1'b0, a: 32'd1024,     d: 32'hDEADBEEF, exp_rd: 32'h00000000, exp_lo: 18'h00000};
      tbl[1] = '{w: 1'b0, r: 1'b1, a: 32'd1024,     d: 32'h0,        exp_rd: 32'hDEADBEEF, exp_lo: 18'h00000};
      tbl[2] = '{w: 1'b1, r: 1'b0, a: 32'd1030,     d: 32'h12345678, exp_rd: 32'hDEADBEEF, exp_lo: 18'h00002};
      tbl[3] = '{w: 1'b0, r: 1'b1, a: 32'd1028,     d: 32'h0,        exp_rd: 32'h12345678, exp_lo: 18'h00002};
      tbl[4] = '{w: 1'b1, r: 1'b0, a: 32'd0,        d: 32'hCAFEF00D, exp_rd: 32'h12345678, exp_lo: 18'h3FE00};
      tbl[5] = '{w: 1'b0, r: 1'b1, a: 32'd0,        d: 32'h0,        exp_rd: 32'hCAFEF00D, exp_lo: 18'h3FE00};
      tbl[6] = '{w: 1'b0, r: 1'b1, a: 32'h00080400, d: 32'h0,        exp_rd: 32'hDEADBEEF, exp_lo: 18'h00000};
      tbl[7] = '{w: 1'b1, r: 1'b1, a: 32'd1032,     d: 32'hA5A55A5A, exp_rd: 32'hDEADBEEF, exp_lo: 18'h00004};
      tbl[8] = '{w: 1'b0, r: 1'b1, a: 32'd1032,     d: 32'h0,        exp_rd: 32'hA5A55A5A, exp_lo: 18'h00004};
      for (int i = 0; i < 9; i++) begin
         do_access(1, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].exp_rd, tbl[i].exp_lo);
         if (tbl[i].w) begin
            check_write_mem(1, tbl[i].exp_lo, tbl[i].d);
            refm[131072 + int'(word_of(tbl[i].a))] = tbl[i].d;
         end
         cur_rd[1] = tbl[i].exp_rd;
         idle(1);
      end

      // W=0: two writes, then back-to-back reads with a single IDLE cycle between them.
      do_access(0, 1'b1, 1'b0, 32'd1028, 32'h11112222, 32'h0, 18'd2);
      check_write_mem(0, 18'd2, 32'h11112222);
      idle(0);
      do_access(0, 1'b1, 1'b0, 32'd1032, 32'h33334444, 32'h0, 18'd4);
      check_write_mem(0, 18'd4, 32'h33334444);
      idle(0);
      do_access(0, 1'b0, 1'b1, 32'd1028, 32'h0, 32'h11112222, 18'd2);
      do_access(0, 1'b0, 1'b1, 32'd1032, 32'h0, 32'h33334444, 18'd4);
      idle(0);
      refm[int'(word_of(32'd1028))] = 32'h11112222;
      refm[int'(word_of(32'd1032))] = 32'h33334444;

      // Reset pulsed in the first HI cycle of a W=1 read.
      @(negedge clk);
      drive(1, 1'b0, 1'b1, 32'd1024, 32'h0);
      repeat (3) @(negedge clk);
      #1;
      chk("pre_rst_in_hi", {14'b0, sa1}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("post_rst_ready", {31'b0, ready1}, 32'd1);
      chk("post_rst_read_data", rdata1, 32'h0);
      chk("post_rst_we_n", {31'b0, we1}, 32'd1);
      chk("post_rst_sram_addr", {14'b0, sa1}, 32'h0);
      chk("post_rst_bus_released", {16'b0, dq1}, 32'h0000BEEF);
      @(negedge clk);
      #1;
      chk("post_rst_still_idle", {31'b0, ready1}, 32'd1);
      cur_rd[0] = 32'h0;
      cur_rd[1] = 32'h0;

      // Randomized accesses against a word-level memory model.
      for (int i = 0; i < 60; i++) begin
         int          s;
         int          k;
         int          key;
         logic        w;
         logic        r;
         logic [31:0] a;
         logic [31:0] d;
         logic [31:0] widx;
         logic [31:0] exp;
         logic [17:0] lo;
         s = (i % 3 == 0) ? 0 : 1;
         k = int'($urandom_range(0, 9));
         w = (k <= 3) || (k == 9);
         r = (k >= 4);
         d = $urandom;
         if ($urandom_range(0, 4) == 0) begin
            a = 32'd1024 - 32'($urandom_range(1, 4)) * 32'd4 + 32'($urandom_range(0, 3));
         end else begin
            a = 32'd1024 + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
         end
         widx = word_of(a);
         lo   = 18'(widx * 32'd2);
         key  = s * 131072 + int'(widx);
         if (w) begin
            exp = cur_rd[s];
         end else if (refm.exists(key)) begin
            exp = refm[key];
         end else begin
            exp = 32'h0;
         end
         do_access(s, w, r, a, d, exp, lo);
         if (w) begin
            check_write_mem(s, lo, d);
            refm[key] = d;
         end else begin
            cur_rd[s] = exp;
         end
         idle(s);
         if ($urandom_range(0, 2) == 0) idle(s);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
